booth_mac_accumulator: RTL

Downstream consumer of `booth_radix8_multiplier`: it takes each single-cycle `done`/`product` result and sums groups of `cfg_len` consecutive products into a wide accumulator. Each completed group is presented on a valid/ready output register. The multiplier has no backpressure, so this block never stalls its input. It reports lost results instead.

---
 rtl/booth_pkg.sv | 18 +
 rtl/booth_sat_add.sv | 50 +++++
 rtl/booth_mac_accumulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared constants and state encodings for the Booth multiplier MAC accumulator.
package booth_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ACC_WIDTH = 40;
    localparam int DEF_CNT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } in_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Accumulator adder: extends the product to ACC_WIDTH and adds it to acc_in.
// With BOOTH_MAC_SAT_EN defined, overflow is detected and the sum clamped; otherwise it wraps.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    input  logic [2*WIDTH-1:0]   product,
    input  logic                 is_signed,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    localparam int EXT_BITS = ACC_WIDTH - 2*WIDTH;

    logic [ACC_WIDTH-1:0] ext;

    assign ext = {{EXT_BITS{is_signed & product[2*WIDTH-1]}}, product};

`ifdef BOOTH_MAC_SAT_EN
    logic [ACC_WIDTH:0] raw;
    logic               signed_ovf;
    logic               unsigned_ovf;

    assign raw          = {1'b0, acc_in} + {1'b0, ext};
    assign signed_ovf   = (acc_in[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                          (raw[ACC_WIDTH-1] != acc_in[ACC_WIDTH-1]);
    assign unsigned_ovf = raw[ACC_WIDTH];

    // Signed overflow can only happen when both operands share a sign, so acc_in's sign picks the rail.
    always_comb begin
        sum = raw[ACC_WIDTH-1:0];
        sat = 1'b0;
        if (is_signed && signed_ovf) begin
            sat = 1'b1;
            sum = acc_in[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else if (!is_signed && unsigned_ovf) begin
            sat = 1'b1;
            sum = '1;
        end
    end
`else
    assign sum = acc_in + ext;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/booth_mac_accumulator.sv
// Sums groups of cfg_len multiplier products into a valid/ready result register.
// Optional clamping adds and out_sat reporting under BOOTH_MAC_SAT_EN; otherwise out_sat stays 0.
//
// in_state | meaning
// ---------+--------------------------------------------
// IDLE     | no group open, cnt = 0, next product starts a group
// ACCUM    | group open, cnt products already summed into acc
//
// out_state | meaning
// ----------+--------------------------------------------
// EMPTY     | no unconsumed result
// FULL      | out_data holds a group sum awaiting out_ready
module booth_mac_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   in_product,
    input  logic                 cfg_signed,
    input  logic [CNT_WIDTH-1:0] cfg_len,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 drop_err
);

    in_state_t            in_state;
    out_state_t           out_state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] add_a;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_sat;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] eff_len;
    logic                 grp_sat;
    logic                 grp_sat_nxt;
    logic                 complete;
    logic                 can_load;

    // The first product of a group is added to zero so one adder serves both states.
    assign add_a = (in_state == ACCUM) ? acc : '0;

    booth_sat_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc_in    (add_a),
        .product   (in_product),
        .is_signed (cfg_signed),
        .sum       (sum),
        .sat       (add_sat)
    );

    assign eff_len     = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
    assign cnt_inc     = cnt + CNT_WIDTH'(1);
    assign complete    = in_valid && ((in_state == IDLE) ? (eff_len == CNT_WIDTH'(1))
                                                         : (cnt_inc == len_q));
    assign grp_sat_nxt = add_sat | ((in_state == ACCUM) & grp_sat);
    assign can_load    = (out_state == EMPTY) || out_ready;
    assign out_valid   = (out_state == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            in_state  <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= CNT_WIDTH'(1);
            grp_sat   <= 1'b0;
            out_state <= EMPTY;
            out_data  <= '0;
            out_sat   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (in_valid) begin
                if (in_state == IDLE) begin
                    len_q <= eff_len;
                end
                if (complete) begin
                    in_state <= IDLE;
                    acc      <= '0;
                    cnt      <= '0;
                    grp_sat  <= 1'b0;
                end else begin
                    in_state <= ACCUM;
                    acc      <= sum;
                    cnt      <= cnt_inc;
                    grp_sat  <= grp_sat_nxt;
                end
            end

            // A completion that finds the register full and unaccepted is lost, old data kept.
            if (complete && can_load) begin
                out_state <= FULL;
                out_data  <= sum;
                out_sat   <= grp_sat_nxt;
            end else if (complete) begin
                drop_err <= 1'b1;
            end else if (out_state == FULL && out_ready) begin
                out_state <= EMPTY;
            end
        end
    end

endmodule
